// File: rtl/hamming_pkg.sv
// Shared helpers for the serial Hamming decoder: code geometry and where
// the parity and data bits sit inside a codeword.
package hamming_pkg;

  function automatic int n_of(input int m);
    return (1 << m) - 1;
  endfunction

  function automatic int k_of(input int m);
    return n_of(m) - m;
  endfunction

  // Bit p is set when codeword position p holds a parity bit.
  function automatic logic [31:0] parity_mask(input int m);
    logic [31:0] mask;
    mask = '0;
    for (int j = 0; j < m; j++) mask[1 << j] = 1'b1;
    return mask;
  endfunction

  // Codeword position (1..N) of data bit i, where i = 0 is d1.
  function automatic int data_pos(input int m, input int i);
    logic [31:0] mask;
    int cnt;
    int pos;
    mask = parity_mask(m);
    cnt  = 0;
    pos  = 0;
    for (int p = 1; p <= n_of(m); p++) begin
      if (!mask[p]) begin
        if (cnt == i) pos = p;
        cnt++;
      end
    end
    return pos;
  endfunction

endpackage

// File: rtl/hamming_syndrome_correct.sv
// Combinational syndrome computation and single-error correction of one
// captured codeword. word[p-1] holds position p; word[N] holds p0 when EXTENDED.
module hamming_syndrome_correct
  import hamming_pkg::*;
#(
  parameter int M        = 3,
  parameter int EXTENDED = 0
) (
  input  logic [n_of(M)+EXTENDED-1:0] word,
  output logic [k_of(M)-1:0]          data,
  output logic [M-1:0]                syndrome,
  output logic                        corrected,
  output logic                        uncorrectable
);

  localparam int N = n_of(M);
  localparam int K = k_of(M);

  logic s_nz;
  logic flip_en;

  always_comb begin
    syndrome = '0;
    for (int p = 1; p <= N; p++) begin
      if (word[p-1]) syndrome = syndrome ^ p[M-1:0];
    end
  end

  assign s_nz = |syndrome;

  // With SECDED, odd overall parity marks a single error; even parity with a
  // nonzero syndrome means two errors, which are passed through untouched.
  generate
    if (EXTENDED != 0) begin : g_secded
      logic par;
      assign par           = ^word;
      assign corrected     = par;
      assign uncorrectable = s_nz & ~par;
      assign flip_en       = s_nz & par;
    end else begin : g_plain
      assign corrected     = s_nz;
      assign uncorrectable = 1'b0;
      assign flip_en       = s_nz;
    end
  endgenerate

  generate
    for (genvar gi = 0; gi < K; gi++) begin : g_data
      localparam int DP = data_pos(M, gi);
      assign data[gi] = word[DP-1] ^ (flip_en && (syndrome == DP[M-1:0]));
    end
  endgenerate

endmodule

// File: rtl/hamming_stream_decoder.sv
// Serial Hamming (optionally SECDED) decoder: deserialises codewords, corrects,
// reserialises the data bits with valid/last framing and counts errors.
module hamming_stream_decoder
  import hamming_pkg::*;
#(
  parameter int M        = 3,
  parameter int EXTENDED = 0,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             s_in,
  input  logic             in_sof,
  output logic             s_out,
  output logic             out_valid,
  output logic             out_last,
  output logic             corrected,
  output logic             uncorrectable,
  output logic [M-1:0]     syndrome,
  output logic [CNT_W-1:0] corr_cnt,
  output logic [CNT_W-1:0] unc_cnt,
  input  logic             cnt_clr
);

  localparam int N  = n_of(M);
  localparam int K  = k_of(M);
  localparam int L  = N + EXTENDED;
  localparam int BW = $clog2(L);
  localparam int KW = $clog2(K);
  localparam logic [BW-1:0] LAST_BIT = BW'(L - 1);
  localparam logic [KW-1:0] LAST_OUT = KW'(K - 1);

  logic [BW-1:0]    bit_cnt_reg;
  logic [L-1:0]     rx_sr_reg;
  logic [L-1:0]     rx_next;
  logic [L-1:0]     cap_word_reg;
  logic             cap_valid_reg;
  logic [K-1:0]     dec_data;
  logic [M-1:0]     dec_syn;
  logic             dec_corr;
  logic             dec_unc;
  logic [K-1:0]     out_sr_reg;
  logic [KW-1:0]    out_cnt_reg;
  logic             out_valid_reg;
  logic             corrected_reg;
  logic             unc_reg;
  logic [M-1:0]     syndrome_reg;
  logic [CNT_W-1:0] corr_cnt_reg;
  logic [CNT_W-1:0] unc_cnt_reg;

  // Bits enter at the top so that after L shifts position 1 sits at bit 0.
  assign rx_next = {s_in, rx_sr_reg[L-1:1]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bit_cnt_reg   <= '0;
      rx_sr_reg     <= '0;
      cap_word_reg  <= '0;
      cap_valid_reg <= 1'b0;
    end else begin
      cap_valid_reg <= 1'b0;
      if (in_valid) begin
        if (in_sof) begin
          rx_sr_reg   <= {s_in, {(L-1){1'b0}}};
          bit_cnt_reg <= BW'(1);
        end else begin
          rx_sr_reg <= rx_next;
          if (bit_cnt_reg == LAST_BIT) begin
            bit_cnt_reg   <= '0;
            cap_word_reg  <= rx_next;
            cap_valid_reg <= 1'b1;
          end else begin
            bit_cnt_reg <= bit_cnt_reg + 1'b1;
          end
        end
      end
    end
  end

  hamming_syndrome_correct #(
    .M        (M),
    .EXTENDED (EXTENDED)
  ) u_correct (
    .word          (cap_word_reg),
    .data          (dec_data),
    .syndrome      (dec_syn),
    .corrected     (dec_corr),
    .uncorrectable (dec_unc)
  );

  // A fresh capture always wins over the drain so back-to-back words abut.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_sr_reg    <= '0;
      out_cnt_reg   <= '0;
      out_valid_reg <= 1'b0;
      corrected_reg <= 1'b0;
      unc_reg       <= 1'b0;
      syndrome_reg  <= '0;
    end else if (cap_valid_reg) begin
      out_sr_reg    <= dec_data;
      out_cnt_reg   <= '0;
      out_valid_reg <= 1'b1;
      corrected_reg <= dec_corr;
      unc_reg       <= dec_unc;
      syndrome_reg  <= dec_syn;
    end else begin
      corrected_reg <= 1'b0;
      unc_reg       <= 1'b0;
      if (out_valid_reg) begin
        out_sr_reg <= out_sr_reg >> 1;
        if (out_cnt_reg == LAST_OUT) out_valid_reg <= 1'b0;
        else                         out_cnt_reg   <= out_cnt_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      corr_cnt_reg <= '0;
      unc_cnt_reg  <= '0;
    end else if (cnt_clr) begin
      corr_cnt_reg <= '0;
      unc_cnt_reg  <= '0;
    end else begin
      if (corrected_reg && (corr_cnt_reg != '1)) corr_cnt_reg <= corr_cnt_reg + 1'b1;
      if (unc_reg && (unc_cnt_reg != '1))        unc_cnt_reg  <= unc_cnt_reg + 1'b1;
    end
  end

  assign s_out         = out_sr_reg[0];
  assign out_valid     = out_valid_reg;
  assign out_last      = out_valid_reg && (out_cnt_reg == LAST_OUT);
  assign corrected     = corrected_reg;
  assign uncorrectable = unc_reg;
  assign syndrome      = syndrome_reg;
  assign corr_cnt      = corr_cnt_reg;
  assign unc_cnt       = unc_cnt_reg;

endmodule

// File: tb/tb_hamming_stream_decoder.sv
// Directed bench: plain (7,4), SECDED (8,4) and a 2-bit-counter instance
// driven with hand-encoded words; every output bit is collected by monitors.
module tb_hamming_stream_decoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, s_in, in_sof, cnt_clr;
  logic vld_a, vld_b, vld_c;

  logic        s_out_a, out_valid_a, out_last_a, corrected_a, uncorrectable_a;
  logic [2:0]  syndrome_a;
  logic [15:0] corr_cnt_a, unc_cnt_a;
  logic        s_out_b, out_valid_b, out_last_b, corrected_b, uncorrectable_b;
  logic [2:0]  syndrome_b;
  logic [15:0] corr_cnt_b, unc_cnt_b;
  logic        s_out_c, out_valid_c, out_last_c, corrected_c, uncorrectable_c;
  logic [2:0]  syndrome_c;
  logic [1:0]  corr_cnt_c, unc_cnt_c;

  hamming_stream_decoder #(.M(3), .EXTENDED(0), .CNT_W(16)) dut_a (
    .clk(clk), .reset(reset), .in_valid(vld_a), .s_in(s_in), .in_sof(in_sof),
    .s_out(s_out_a), .out_valid(out_valid_a), .out_last(out_last_a),
    .corrected(corrected_a), .uncorrectable(uncorrectable_a), .syndrome(syndrome_a),
    .corr_cnt(corr_cnt_a), .unc_cnt(unc_cnt_a), .cnt_clr(cnt_clr)
  );

  hamming_stream_decoder #(.M(3), .EXTENDED(1), .CNT_W(16)) dut_b (
    .clk(clk), .reset(reset), .in_valid(vld_b), .s_in(s_in), .in_sof(in_sof),
    .s_out(s_out_b), .out_valid(out_valid_b), .out_last(out_last_b),
    .corrected(corrected_b), .uncorrectable(uncorrectable_b), .syndrome(syndrome_b),
    .corr_cnt(corr_cnt_b), .unc_cnt(unc_cnt_b), .cnt_clr(cnt_clr)
  );

  hamming_stream_decoder #(.M(3), .EXTENDED(0), .CNT_W(2)) dut_c (
    .clk(clk), .reset(reset), .in_valid(vld_c), .s_in(s_in), .in_sof(in_sof),
    .s_out(s_out_c), .out_valid(out_valid_c), .out_last(out_last_c),
    .corrected(corrected_c), .uncorrectable(uncorrectable_c), .syndrome(syndrome_c),
    .corr_cnt(corr_cnt_c), .unc_cnt(unc_cnt_c), .cnt_clr(cnt_clr)
  );

  // Words as sent, bit 0 = position 1; data 1011 -> {d4,d3,d2,d1} = 4'b1101.
  localparam logic [7:0] W_CLEAN  = 8'b0110_0110;
  localparam logic [7:0] W_ERR5   = 8'b0111_0110;
  localparam logic [7:0] W_DBL    = 8'b0100_0010;
  localparam logic [7:0] W_P0ONLY = 8'b1110_0110;
  localparam logic [3:0] D_1011   = 4'b1101;

  int n_checks = 0;
  int n_fail   = 0;
  int corr_seen_a = 0, unc_seen_a = 0;
  int corr_seen_b = 0, unc_seen_b = 0;
  int corr_seen_c = 0, unc_seen_c = 0;
  logic [1:0] q_a[$];
  logic [1:0] q_b[$];
  logic [1:0] q_c[$];

  always @(negedge clk) begin
    if (out_valid_a) q_a.push_back({out_last_a, s_out_a});
    if (out_valid_b) q_b.push_back({out_last_b, s_out_b});
    if (out_valid_c) q_c.push_back({out_last_c, s_out_c});
    if (corrected_a) corr_seen_a++;
    if (uncorrectable_a) unc_seen_a++;
    if (corrected_b) corr_seen_b++;
    if (uncorrectable_b) unc_seen_b++;
    if (corrected_c) corr_seen_c++;
    if (uncorrectable_c) unc_seen_c++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic set_valid(input int sel, input logic v);
    case (sel)
      0:       vld_a = v;
      1:       vld_b = v;
      default: vld_c = v;
    endcase
  endtask

  // Leaves in_valid high after the last bit so consecutive calls abut.
  task automatic send_word(input int sel, input logic [7:0] w, input int len,
                           input logic sof, input logic gaps);
    for (int i = 0; i < len; i++) begin
      if (gaps && i[0]) begin
        @(negedge clk);
        set_valid(sel, 1'b0);
        in_sof = 1'b0;
        s_in   = ~w[i];
      end
      @(negedge clk);
      set_valid(sel, 1'b1);
      s_in   = w[i];
      in_sof = sof && (i == 0);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    vld_a = 1'b0; vld_b = 1'b0; vld_c = 1'b0;
    in_sof = 1'b0; s_in = 1'b0;
  endtask

  task automatic drain();
    repeat (8) @(negedge clk);
  endtask

  task automatic get_word(input int sel, output logic [3:0] d, output logic [3:0] l, output int n);
    logic [1:0] e;
    d = '0; l = '0; n = 0;
    for (int i = 0; i < 4; i++) begin
      e = 2'b00;
      case (sel)
        0:       if (q_a.size() > 0) begin e = q_a.pop_front(); n++; end
        1:       if (q_b.size() > 0) begin e = q_b.pop_front(); n++; end
        default: if (q_c.size() > 0) begin e = q_c.pop_front(); n++; end
      endcase
      d[i] = e[0];
      l[i] = e[1];
    end
  endtask

  task automatic check_word(input string tag, input int sel, input logic [3:0] exp);
    logic [3:0] d, l;
    int n;
    get_word(sel, d, l, n);
    check({tag, "_nbits"}, n, 4);
    check({tag, "_data"}, d, exp);
    check({tag, "_last"}, l, 4'b1000);
  endtask

  initial begin
    reset = 1'b0; s_in = 1'b0; in_sof = 1'b0; cnt_clr = 1'b0;
    vld_a = 1'b0; vld_b = 1'b0; vld_c = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_out_valid", out_valid_a, 0);
    check("rst_s_out", s_out_a, 0);
    check("rst_out_last", out_last_a, 0);
    check("rst_syndrome", syndrome_a, 0);
    check("rst_corr_cnt", corr_cnt_a, 0);
    @(negedge clk);
    reset = 1'b1;

    send_word(0, W_CLEAN, 7, 1'b0, 1'b0); idle(); drain();
    check_word("clean", 0, D_1011);
    check("clean_syn", syndrome_a, 0);
    check("clean_pulses", corr_seen_a, 0);

    send_word(0, W_ERR5, 7, 1'b0, 1'b0); idle(); drain();
    check_word("single", 0, D_1011);
    check("single_syn", syndrome_a, 5);
    check("single_pulses", corr_seen_a, 1);
    check("single_cnt", corr_cnt_a, 1);

    send_word(0, 8'b0000_0111, 3, 1'b0, 1'b0);
    send_word(0, W_CLEAN, 7, 1'b1, 1'b1); idle(); drain();
    check("sof_nbits", q_a.size(), 4);
    check_word("sof", 0, D_1011);
    check("sof_syn", syndrome_a, 0);
    check("sof_pulses", corr_seen_a, 1);

    send_word(0, W_CLEAN, 7, 1'b0, 1'b0);
    send_word(0, W_ERR5, 7, 1'b0, 1'b0); idle(); drain();
    check("b2b_nbits", q_a.size(), 8);
    check_word("b2b_w1", 0, D_1011);
    check_word("b2b_w2", 0, D_1011);
    check("b2b_syn", syndrome_a, 5);
    check("b2b_cnt", corr_cnt_a, 2);

    send_word(0, W_ERR5, 7, 1'b0, 1'b0); idle();
    @(negedge clk);
    check("clr_pulse", corrected_a, 1);
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    check("clr_pulse_end", corrected_a, 0);
    check("clr_cnt", corr_cnt_a, 0);
    drain();
    check_word("clr_word", 0, D_1011);
    check("clr_cnt_hold", corr_cnt_a, 0);

    send_word(0, W_ERR5, 7, 1'b0, 1'b0); idle();
    repeat (2) @(negedge clk);
    check("mid_valid_before", out_valid_a, 1);
    check("mid_cnt_before", corr_cnt_a, 1);
    reset = 1'b0;
    #1;
    check("mid_rst_valid", out_valid_a, 0);
    check("mid_rst_s_out", s_out_a, 0);
    check("mid_rst_syn", syndrome_a, 0);
    check("mid_rst_cnt", corr_cnt_a, 0);
    @(negedge clk);
    reset = 1'b1;
    send_word(0, 8'b0000_0101, 3, 1'b0, 1'b0); idle();
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    q_a.delete();
    send_word(0, W_CLEAN, 7, 1'b0, 1'b0); idle(); drain();
    check("restart_nbits", q_a.size(), 4);
    check_word("restart", 0, D_1011);

    send_word(1, W_DBL, 8, 1'b0, 1'b0); idle(); drain();
    check_word("dbl", 1, 4'b1000);
    check("dbl_syn", syndrome_b, 5);
    check("dbl_unc_pulses", unc_seen_b, 1);
    check("dbl_corr_pulses", corr_seen_b, 0);
    check("dbl_unc_cnt", unc_cnt_b, 1);

    send_word(1, W_P0ONLY, 8, 1'b0, 1'b0); idle(); drain();
    check_word("p0", 1, D_1011);
    check("p0_syn", syndrome_b, 0);
    check("p0_corr_pulses", corr_seen_b, 1);
    check("p0_corr_cnt", corr_cnt_b, 1);
    check("p0_unc_cnt", unc_cnt_b, 1);

    for (int w = 0; w < 4; w++) begin
      send_word(2, W_ERR5, 7, 1'b0, 1'b0); idle(); drain();
      check_word("sat_word", 2, D_1011);
      check("sat_cnt", corr_cnt_c, (w < 3) ? w + 1 : 3);
    end
    check("sat_syn", syndrome_c, 5);
    check("sat_unc_cnt", unc_cnt_c, 0);
    check("plain_unc_pulses", unc_seen_a + unc_seen_c, 0);
    check("plain_unc_cnt", unc_cnt_a, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
